// File: rtl/div_dec.sv
// ---------------------------------------------------------------------------
// div_dec -- sequential decimal long divider.
//
// Divides an 8-digit decimal dividend by a 4-digit decimal divisor using
// restoring long division one decimal digit at a time. Each quotient digit is
// found by up to nine trial subtractions of the binary divisor from a binary
// partial remainder. Operands are captured when start is accepted, so the
// input ports may change freely while an operation runs.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          request a division (sampled only while idle)
//   z0..z7         dividend digits, z0 most significant (signed W)
//   x0..x3         divisor digits, x0 most significant (signed W)
//   q0..q7         quotient digits, q0 most significant (registered)
//   r0..r3         remainder digits, r0 most significant (registered)
//   busy           high while an operation is in progress
//   done           one-cycle pulse in the first idle cycle after results land
//   err            registered error flag of the last operation
//
// Fixed timing: a valid operation keeps busy high for 82 cycles
// (LOAD + 8 x (SHIFT + 9 x SUB) + FIN); an operation with a bad operand
// goes LOAD -> FIN and takes 2 cycles.
// ---------------------------------------------------------------------------
module div_dec #(
    parameter int W  = 32,
    parameter int ND = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] z0,
    input  logic signed [W-1:0] z1,
    input  logic signed [W-1:0] z2,
    input  logic signed [W-1:0] z3,
    input  logic signed [W-1:0] z4,
    input  logic signed [W-1:0] z5,
    input  logic signed [W-1:0] z6,
    input  logic signed [W-1:0] z7,
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] x3,
    output logic signed [W-1:0] q0,
    output logic signed [W-1:0] q1,
    output logic signed [W-1:0] q2,
    output logic signed [W-1:0] q3,
    output logic signed [W-1:0] q4,
    output logic signed [W-1:0] q5,
    output logic signed [W-1:0] q6,
    output logic signed [W-1:0] q7,
    output logic signed [W-1:0] r0,
    output logic signed [W-1:0] r1,
    output logic signed [W-1:0] r2,
    output logic signed [W-1:0] r3,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SUB   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic signed [W-1:0] NINE = W'(9);

    logic [2:0]          state;

    logic signed [W-1:0] z_reg [ND];
    logic signed [W-1:0] x_reg [4];

    // Binary divisor (<= 9999) and partial remainder (<= 99999 after a shift)
    logic [13:0]         d_val;
    logic [16:0]         rem;
    logic [3:0]          cnt;
    logic [3:0]          sub_cyc;
    logic [2:0]          idx;
    logic [3:0]          q_acc [ND];
    logic                err_cond;

    logic signed [W-1:0] q_out [ND];
    logic signed [W-1:0] r_out [4];

    logic                load_bad;
    logic [13:0]         d_calc;
    logic [16:0]         shift_val;
    logic [16:0]         rem_sub;
    logic                rem_ge;
    logic [3:0]          cnt_next;

    function automatic logic digit_ok(input logic signed [W-1:0] v);
        return !v[W-1] && (v <= NINE);
    endfunction

    // Operand validation and binary divisor formation from the captured
    // digits. Only the low nibble feeds the divisor; out-of-range digits
    // are flagged by load_bad and never reach the datapath.
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (!digit_ok(z_reg[i])) load_bad = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (!digit_ok(x_reg[i])) load_bad = 1'b1;
        end
        d_calc = 14'(x_reg[0][3:0]) * 14'd1000
               + 14'(x_reg[1][3:0]) * 14'd100
               + 14'(x_reg[2][3:0]) * 14'd10
               + 14'(x_reg[3][3:0]);
        if (d_calc == 14'd0) load_bad = 1'b1;
    end

    // Datapath helpers: bring down the next dividend digit, and one trial
    // subtraction. Because rem < D before every shift, the shifted value
    // stays below 10*D, so nine trial cycles always suffice.
    always_comb begin
        shift_val = rem * 17'd10 + 17'(z_reg[idx][3:0]);
        rem_ge    = (rem >= 17'(d_val));
        rem_sub   = rem - 17'(d_val);
        cnt_next  = rem_ge ? cnt + 4'd1 : cnt;
    end

    assign busy = (state != S_IDLE);

    // Control sequencer. SUB always runs its full nine cycles regardless of
    // when the subtraction stops succeeding, which keeps latency fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_LOAD;
                S_LOAD:  state <= load_bad ? S_FIN : S_SHIFT;
                S_SHIFT: state <= S_SUB;
                S_SUB: begin
                    if (sub_cyc == 4'd8) state <= (idx == 3'd7) ? S_FIN : S_SHIFT;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture on the accepting edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) z_reg[i] <= '0;
            for (int i = 0; i < 4; i++)  x_reg[i] <= '0;
        end else if (state == S_IDLE && start) begin
            z_reg[0] <= z0;
            z_reg[1] <= z1;
            z_reg[2] <= z2;
            z_reg[3] <= z3;
            z_reg[4] <= z4;
            z_reg[5] <= z5;
            z_reg[6] <= z6;
            z_reg[7] <= z7;
            x_reg[0] <= x0;
            x_reg[1] <= x1;
            x_reg[2] <= x2;
            x_reg[3] <= x3;
        end
    end

    // Long-division datapath. The quotient digit written at SUB exit must
    // include the last trial cycle's outcome, hence cnt_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_val    <= '0;
            rem      <= '0;
            cnt      <= '0;
            sub_cyc  <= '0;
            idx      <= '0;
            err_cond <= 1'b0;
            for (int i = 0; i < ND; i++) q_acc[i] <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    err_cond <= load_bad;
                    d_val    <= d_calc;
                    rem      <= '0;
                    idx      <= '0;
                end
                S_SHIFT: begin
                    rem     <= shift_val;
                    cnt     <= '0;
                    sub_cyc <= '0;
                end
                S_SUB: begin
                    if (rem_ge) rem <= rem_sub;
                    cnt     <= cnt_next;
                    sub_cyc <= sub_cyc + 4'd1;
                    if (sub_cyc == 4'd8) begin
                        q_acc[idx] <= cnt_next;
                        idx        <= idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: updated only in FIN so they hold across the next
    // operation until its own FIN. The remainder is below 10000, so the
    // constant divides yield single decimal digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) q_out[i] <= '0;
            for (int i = 0; i < 4; i++)  r_out[i] <= '0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == S_FIN);
            if (state == S_FIN) begin
                err <= err_cond;
                if (err_cond) begin
                    for (int i = 0; i < ND; i++) q_out[i] <= '0;
                    for (int i = 0; i < 4; i++)  r_out[i] <= '0;
                end else begin
                    for (int i = 0; i < ND; i++) q_out[i] <= W'(q_acc[i]);
                    r_out[0] <= W'(rem / 17'd1000);
                    r_out[1] <= W'((rem / 17'd100) % 17'd10);
                    r_out[2] <= W'((rem / 17'd10) % 17'd10);
                    r_out[3] <= W'(rem % 17'd10);
                end
            end
        end
    end

    assign q0 = q_out[0];
    assign q1 = q_out[1];
    assign q2 = q_out[2];
    assign q3 = q_out[3];
    assign q4 = q_out[4];
    assign q5 = q_out[5];
    assign q6 = q_out[6];
    assign q7 = q_out[7];
    assign r0 = r_out[0];
    assign r1 = r_out[1];
    assign r2 = r_out[2];
    assign r3 = r_out[3];

endmodule

// File: doc/div_dec.md
DIV_DEC -- requirements
Module: div_dec

Interface
REQ-001 SHALL have parameter W, default 32, giving the width of every digit port.
REQ-002 SHALL have parameter ND, default 8, giving the number of dividend and quotient digits; only 8 is supported.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 z0..z7  input  signed W each  dividend decimal digits; z0 is the most significant.
REQ-007 x0..x3  input  signed W each  divisor decimal digits; x0 is the most significant.
REQ-008 q0..q7  output  signed W each  quotient decimal digits; q0 is the most significant; registered.
REQ-009 r0..r3  output  signed W each  remainder decimal digits; r0 is the most significant; registered.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when the results become valid.
REQ-012 err  output  1  registered error flag for the last operation.

Function
REQ-013 SHALL capture z0..z7 and x0..x3 into internal registers on the edge that accepts start; later input changes do not affect the operation.
REQ-014 SHALL implement the FSM states IDLE, LOAD, SHIFT, SUB and FIN.
- IDLE -> LOAD on start=1.
- LOAD -> SHIFT, or LOAD -> FIN on error.
- SHIFT -> SUB.
- SUB -> SHIFT after 9 cycles while digits remain; SUB -> FIN after the 8th digit.
- FIN -> IDLE.
REQ-015 LOAD SHALL check every captured digit for range 0..9.
- Any digit outside 0..9 (including negative), or a divisor value of 0, sets the error condition.
- Otherwise LOAD forms the binary divisor D = x0*1000 + x1*100 + x2*10 + x3, clears the partial remainder R and clears the digit index.
REQ-016 SHIFT SHALL set R = 10*R + z[index], where index runs 0..7 from the most significant digit, and SHALL clear the current quotient digit counter.
REQ-017 SUB SHALL last exactly 9 cycles per digit; in each cycle, if R >= D then R = R - D and the quotient digit counter increments, otherwise R and the counter hold.
REQ-018 At SUB exit, the counter value SHALL be written to quotient digit q[index] and the index SHALL increment.
REQ-019 The internal width of R SHALL be at least 17 bits unsigned (R <= 99999); the counter SHALL be at least 4 bits.
REQ-020 FIN SHALL register the outputs:
- r0..r3 = decimal digits of R (R < D <= 9999), taken by constant division and modulo by 1000, 100 and 10.
- err = error condition.
- On error: q0..q7 = 0, r0..r3 = 0, err = 1.
REQ-021 Fixed latency SHALL be as follows:
- Valid operation: busy=1 for exactly 82 cycles after the accepting edge (LOAD 1 + 8×(1+9) + FIN 1); done=1 in the cycle immediately after FIN, which is also the first IDLE cycle.
- Error operation: done follows after LOAD and FIN only, i.e. 2 busy cycles.
REQ-022 done SHALL be high for exactly one cycle per accepted start.
REQ-023 busy SHALL be low in IDLE, including the done cycle.
REQ-024 q, r and err SHALL hold their values until the FIN of the next operation.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 start=1 in the done cycle SHALL be accepted as a new operation.
REQ-027 Results SHALL satisfy dividend = quotient*D + remainder with 0 <= remainder < D.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, q0..q7=0, r0..r3=0, R=0, D=0 and index=0, regardless of clk.
REQ-029 A reset mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises is processed normally.

Verification
REQ-030 z=1,2,3,4,5,6,7,8, x=1,2,3,4, start one cycle -> done exactly 82 cycles later; q=0,0,0,1,0,0,0,4; r=0,7,4,2; err=0.
REQ-031 z=9,9,9,9,9,9,9,9, x=9,9,9,9 -> q=0,0,0,1,0,0,0,1; r=0,0,0,0; err=0.
REQ-032 z=0,0,0,0,0,0,0,5, x=0,0,0,7 -> q all 0; r=0,0,0,5.
REQ-033 Error cases -> err=1, q=0, r=0, done 2 cycles after start:
- x=0,0,0,0 with any z.
- z3=10.
- x1=-1.
REQ-034 Start a valid operation, pulse start again at cycles 10 and 50, then assert rst_n=0 at cycle 40 of a second operation:
- The extra starts are ignored; the first operation's result is unchanged.
- Reset clears all outputs and busy asynchronously, with no done pulse.
- The next start yields the correct result.
REQ-035 Back-to-back: start held high through the done cycle -> the second operation begins in that cycle, the first operation's results remain visible until the second FIN, and the two done pulses are 83 cycles apart.
